// File: rtl/note_sequencer.sv
// Note-table sequencer: plays stored {freq, wave, duration} entries with a gate gap.
// Optional `SEQ_LOOP_EN enables loop_i to restart the table after the last entry.
module note_sequencer #(
  parameter int unsigned depth_p     = 8,
  parameter int unsigned dur_width_p = 16,
  parameter int unsigned tick_div_p  = 12_000,
  parameter int unsigned gap_p       = 1_200
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [15:0]                    wr_freq_i,
  input  logic [3:0]                     wr_wave_i,
  input  logic [dur_width_p-1:0]         wr_dur_i,
  input  logic                           clear_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic                           loop_i,
  output logic [15:0]                    freq_o,
  output logic [3:0]                     sw_o,
  output logic                           gate_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [$clog2(depth_p)-1:0]     note_idx_o,
  output logic [$clog2(depth_p+1)-1:0]   count_o
);

  localparam int unsigned IDX_W  = $clog2(depth_p);
  localparam int unsigned CNT_W  = $clog2(depth_p + 1);
  localparam int unsigned TICK_W = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
  localparam int unsigned GAP_W  = (gap_p > 1) ? $clog2(gap_p) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(tick_div_p - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((gap_p > 0) ? gap_p - 1 : 0);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(depth_p);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]       count_q, count_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [dur_width_p-1:0] durc_q, durc_d;
  logic [GAP_W-1:0]       gapc_q, gapc_d;
  logic [15:0]            freq_q, freq_d;
  logic [3:0]             sw_q, sw_d;
  logic                   gate_q, gate_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_ready_q, wr_ready_d;

  logic [15:0]            freq_mem_q [depth_p];
  logic [3:0]             wave_mem_q [depth_p];
  logic [dur_width_p-1:0] dur_mem_q  [depth_p];

  logic                   wr_en;
  logic                   load;
  logic                   advance;
  logic                   loop_en;
  logic [dur_width_p-1:0] cur_dur;
  logic [dur_width_p-1:0] dur_last;

`ifdef SEQ_LOOP_EN
  assign loop_en = loop_i;
`else
  logic unused_loop;
  assign unused_loop = loop_i;
  assign loop_en     = 1'b0;
`endif

  // A zero duration still sounds for one full tick.
  assign cur_dur  = dur_mem_q[idx_q];
  assign dur_last = (cur_dur == '0) ? '0 : cur_dur - dur_width_p'(1);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      freq_mem_q[count_q[IDX_W-1:0]] <= wr_freq_i;
      wave_mem_q[count_q[IDX_W-1:0]] <= wr_wave_i;
      dur_mem_q[count_q[IDX_W-1:0]]  <= wr_dur_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    tick_d   = tick_q;
    durc_d   = durc_q;
    gapc_d   = gapc_q;
    freq_d   = freq_q;
    sw_d     = sw_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_i) begin
          count_d = '0;
        end else if (wr_valid_i && wr_ready_q) begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
        if (start_i && !clear_i && (count_q != '0)) begin
          idx_d = '0;
          load  = 1'b1;
        end
      end
      PLAY: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          durc_d = durc_q + dur_width_p'(1);
          if (durc_q == dur_last) begin
            durc_d = '0;
            if (gap_p > 0) begin
              state_d = GAP;
              gapc_d  = '0;
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
      GAP: begin
        gapc_d = gapc_q + GAP_W'(1);
        if (gapc_q == GAP_LAST) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if ((CNT_W'(idx_q) + CNT_W'(1)) < count_q) begin
        idx_d = idx_q + IDX_W'(1);
        load  = 1'b1;
      end else if (loop_en) begin
        idx_d = '0;
        load  = 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (load) begin
      state_d = PLAY;
      freq_d  = freq_mem_q[idx_d];
      sw_d    = wave_mem_q[idx_d];
      tick_d  = '0;
      durc_d  = '0;
    end

    // Abort overrides any same-cycle advance, load or completion.
    if ((state_q != IDLE) && stop_i) begin
      state_d = IDLE;
      idx_d   = idx_q;
      done_d  = 1'b0;
    end

    if (state_d == IDLE) begin
      freq_d = '0;
      sw_d   = '0;
      tick_d = '0;
      durc_d = '0;
      gapc_d = '0;
    end

    gate_d     = (state_d == PLAY);
    busy_d     = (state_d != IDLE);
    wr_ready_d = (state_d == IDLE) && (count_d < DEPTH_C);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      tick_q     <= '0;
      durc_q     <= '0;
      gapc_q     <= '0;
      freq_q     <= '0;
      sw_q       <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      durc_q     <= durc_d;
      gapc_q     <= gapc_d;
      freq_q     <= freq_d;
      sw_q       <= sw_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign wr_ready_o = wr_ready_q;
  assign freq_o     = freq_q;
  assign sw_o       = sw_q;
  assign gate_o     = gate_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign note_idx_o = idx_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: expected note/gap/end events are queued from
// a table model; a negedge monitor reconstructs events from the outputs and compares.
module tb_note_sequencer;

  localparam int DEPTH = 4;
  localparam int TDIV  = 4;
  localparam int GAPC  = 2;

  localparam int K_NOTE = 0;
  localparam int K_GAP  = 1;
  localparam int K_END  = 2;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [15:0] wr_freq_i = '0;
  logic [3:0]  wr_wave_i = '0;
  logic [15:0] wr_dur_i = '0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        loop_i = 1'b0;
  logic [15:0] freq_o;
  logic [3:0]  sw_o;
  logic        gate_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  note_idx_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  note_sequencer #(
    .depth_p    (DEPTH),
    .dur_width_p(16),
    .tick_div_p (TDIV),
    .gap_p      (GAPC)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_freq_i  (wr_freq_i),
    .wr_wave_i  (wr_wave_i),
    .wr_dur_i   (wr_dur_i),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .loop_i     (loop_i),
    .freq_o     (freq_o),
    .sw_o       (sw_o),
    .gate_o     (gate_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .note_idx_o (note_idx_o),
    .count_o    (count_o)
  );

  typedef struct {
    int kind;
    int freq;
    int sw;
    int idx;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Reference table and playback status as the spec describes them.
  int mf[$];
  int mw[$];
  int md[$];
  bit m_busy = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic emit(input ev_t a);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: actual kind=%0d freq=%0d sw=%0d idx=%0d len=%0d required none",
               a.kind, a.freq, a.sw, a.idx, a.len);
    end else begin
      e = exp_q.pop_front();
      if (a.kind != e.kind || a.freq != e.freq || a.sw != e.sw || a.idx != e.idx || a.len != e.len) begin
        errors++;
        $display("FAIL event: actual kind=%0d freq=%0d sw=%0d idx=%0d len=%0d required kind=%0d freq=%0d sw=%0d idx=%0d len=%0d",
                 a.kind, a.freq, a.sw, a.idx, a.len, e.kind, e.freq, e.sw, e.idx, e.len);
      end
    end
  endtask

  initial begin : monitor
    bit pg, pb;
    int hi, lo, cf, cs, ci;
    pg = 0; pb = 0; hi = 0; lo = 0; cf = 0; cs = 0; ci = 0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        pg = 0; pb = 0; hi = 0; lo = 0;
      end else begin
        if (gate_o && !pg) begin
          if (pb) emit('{K_GAP, 0, 0, 0, lo});
          hi = 1; cf = int'(freq_o); cs = int'(sw_o); ci = int'(note_idx_o);
        end else if (gate_o) begin
          hi++;
        end
        if (!gate_o && pg) begin
          emit('{K_NOTE, cf, cs, ci, hi});
          lo = 1;
        end else if (!gate_o && busy_o) begin
          lo++;
        end
        if (!busy_o && pb) begin
          if (!pg) emit('{K_GAP, 0, 0, 0, lo});
          emit('{K_END, int'(freq_o), int'(sw_o), int'(gate_o), int'(done_o)});
        end else if (done_o) begin
          emit('{K_END, int'(freq_o), int'(sw_o), int'(gate_o), 1});
        end
        pg = gate_o; pb = busy_o;
      end
    end
  end

  task automatic expect_play(input int passes, input int done_flag);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < mf.size(); i++) begin
        exp_q.push_back('{K_NOTE, mf[i], mw[i], i, ((md[i] == 0) ? 1 : md[i]) * TDIV});
        exp_q.push_back('{K_GAP, 0, 0, 0, GAPC});
      end
    end
    exp_q.push_back('{K_END, 0, 0, 0, done_flag});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    mf.delete(); mw.delete(); md.delete();
    exp_q.delete();
    m_busy = 1'b0;
  endtask

  task automatic do_write(input int f, input int w, input int d);
    @(negedge clk);
    wr_valid_i = 1'b1;
    wr_freq_i  = 16'(f);
    wr_wave_i  = 4'(w);
    wr_dur_i   = 16'(d);
    @(negedge clk);
    wr_valid_i = 1'b0;
    if (!m_busy && mf.size() < DEPTH) begin
      mf.push_back(f); mw.push_back(w); md.push_back(d);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    if (!m_busy) begin
      mf.delete(); mw.delete(); md.delete();
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    if (mf.size() > 0) m_busy = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, int'(busy_o), 0);
    m_busy = 1'b0;
    @(negedge clk);
    check({name, "_events_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_note(input string name, input int idx, input int budget);
    int n;
    n = 0;
    while (!(gate_o && int'(note_idx_o) == idx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_wait_note"}, int'(gate_o && int'(note_idx_o) == idx), 1);
  endtask

  task automatic write_demo();
    do_write(440, 4'b0001, 2);
    do_write(880, 4'b0010, 1);
    do_write(220, 4'b1000, 0);
  endtask

  initial begin
    // 1. reset state
    do_reset();
    check("rst_freq", int'(freq_o), 0);
    check("rst_sw", int'(sw_o), 0);
    check("rst_gate", int'(gate_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_idx", int'(note_idx_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_ready", int'(wr_ready_o), 1);

    // 2. three-note playback
    write_demo();
    check("demo_count", int'(count_o), 3);
    expect_play(1, 1);
    pulse_start();
    wait_idle("demo", 300);
    check("demo_freq_after", int'(freq_o), 0);
    check("demo_ready_after", int'(wr_ready_o), 1);

    // 3. full table, overflow write, clear vs write
    do_clear();
    check("clr_count", int'(count_o), 0);
    for (int i = 0; i < DEPTH; i++) do_write(100 + i, 1 << i, i);
    check("full_ready", int'(wr_ready_o), 0);
    check("full_count", int'(count_o), DEPTH);
    do_write(999, 1, 1);
    check("overflow_count", int'(count_o), DEPTH);
    @(negedge clk);
    clear_i = 1'b1; wr_valid_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; wr_valid_i = 1'b0;
    mf.delete(); mw.delete(); md.delete();
    check("clrwr_full_count", int'(count_o), 0);
    do_write(5, 1, 1);
    @(negedge clk);
    clear_i = 1'b1; wr_valid_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; wr_valid_i = 1'b0;
    mf.delete(); mw.delete(); md.delete();
    check("clrwr_count", int'(count_o), 0);
    check("clrwr_ready", int'(wr_ready_o), 1);

    // 4. stop on cycle 2 of note 2
    write_demo();
    exp_q.push_back('{K_NOTE, 440, 1, 0, 8});
    exp_q.push_back('{K_GAP, 0, 0, 0, GAPC});
    exp_q.push_back('{K_NOTE, 880, 2, 1, 2});
    exp_q.push_back('{K_END, 0, 0, 0, 0});
    pulse_start();
    wait_note("stop", 1, 60);
    @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("stop_gate", int'(gate_o), 0);
    check("stop_busy", int'(busy_o), 0);
    check("stop_freq", int'(freq_o), 0);
    check("stop_done", int'(done_o), 0);
    @(negedge clk);
    check("stop_done_late", int'(done_o), 0);
    wait_idle("stop", 10);

    // 5. start with empty table; start/write/clear while busy
    do_clear();
    pulse_start();
    check("empty_start_busy", int'(busy_o), 0);
    write_demo();
    expect_play(1, 1);
    pulse_start();
    do_write(1234, 4, 3);
    pulse_start();
    do_clear();
    wait_idle("busy_ignore", 300);
    check("busy_ignore_count", int'(count_o), 3);

    // 6. looping
    loop_i = 1'b1;
`ifdef SEQ_LOOP_EN
    expect_play(2, 1);
    pulse_start();
    wait_note("loop_last", 2, 100);
    wait_note("loop_wrap", 0, 100);
    check("loop_idx", int'(note_idx_o), 0);
    check("loop_freq", int'(freq_o), 440);
    loop_i = 1'b0;
    wait_idle("loop", 300);
`else
    expect_play(1, 1);
    pulse_start();
    wait_idle("noloop", 300);
    loop_i = 1'b0;
`endif

    // randomized tables
    for (int r = 0; r < 8; r++) begin
      int n;
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++)
        do_write($urandom_range(0, 65535), $urandom_range(0, 15), $urandom_range(0, 3));
      check("rnd_count", int'(count_o), mf.size());
      expect_play(1, 1);
      pulse_start();
      if ($urandom_range(0, 1) == 1) do_write($urandom_range(0, 65535), 1, 1);
      wait_idle("rnd", 400);
      check("rnd_count_after", int'(count_o), mf.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
